// File: rtl/sram_async_ctrl.sv
// -----------------------------------------------------------------------------
// sram_async_ctrl
// Bus-side initiator for a 256K x 16 asynchronous SRAM (10 ns part).
// Turns single-beat synchronous read/write requests into timed SRAM pin
// sequences. Only one access is in flight at a time.
//
// Parameters
//   RD_WAIT   clk cycles from address/CE_n/OE_n valid to data sample (>= 1)
//   WE_PULSE  clk cycles WE_n is held low (>= 1)
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/addr/be/wdata  request attributes, latched on acceptance
//   rsp_valid             one-cycle completion pulse (reads and writes)
//   rsp_rdata             read data, disabled byte lanes forced to 0x00
//   sram_addr, sram_data  SRAM address pins and bidirectional data bus
//   sram_*_n              active-low SRAM strobes, all direct flop outputs
// -----------------------------------------------------------------------------
module sram_async_ctrl #(
    parameter int RD_WAIT  = 2,
    parameter int WE_PULSE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [17:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] TURN   = 3'd2;
    localparam logic [2:0] WSETUP = 3'd3;
    localparam logic [2:0] WPULSE = 3'd4;
    localparam logic [2:0] WHOLD  = 3'd5;

    // Terminal counts: the counter starts at 0 on entry to the timed state.
    localparam logic [7:0] RD_LAST = 8'(RD_WAIT - 1);
    localparam logic [7:0] WE_LAST = 8'(WE_PULSE - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_ready;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;
    logic        r_drive;
    logic        r_rsp_valid;
    logic [15:0] r_rdata;
    logic [17:0] r_addr;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_lb_n;
    logic        r_ub_n;

    logic [15:0] w_rd_masked;

    // Byte lanes that were not enabled read back as zero, whatever the
    // (possibly floating) bus carries on them.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign w_rd_masked[gi*8 +: 8] = r_be[gi] ? sram_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // The bus is driven only from WSETUP through WHOLD; OE_n is high there.
    assign sram_data = r_drive ? r_wdata : 16'hzzzz;

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_lb_n = r_lb_n;
    assign sram_ub_n = r_ub_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_ready     <= 1'b1;
            r_be        <= 2'b00;
            r_wdata     <= 16'h0000;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 16'h0000;
            r_addr      <= 18'd0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_ready <= 1'b0;
                        r_addr  <= req_addr;
                        r_be    <= req_be;
                        r_wdata <= req_wdata;
                        r_ce_n  <= 1'b0;
                        r_lb_n  <= ~req_be[0];
                        r_ub_n  <= ~req_be[1];
                        r_cnt   <= 8'd0;
                        if (req_we) begin
                            r_state <= WSETUP;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= RD;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_rdata     <= w_rd_masked;
                        r_rsp_valid <= 1'b1;
                        r_ce_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_lb_n      <= 1'b1;
                        r_ub_n      <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_state     <= TURN;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                TURN: begin
                    // Gives the SRAM its output-disable time before anyone
                    // can start driving the bus again.
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                WSETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= WPULSE;
                end
                WPULSE: begin
                    if (r_cnt == WE_LAST) begin
                        r_we_n  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= WHOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WHOLD: begin
                    // Address and data stayed put through WE_n rising; now
                    // close the CE_n window and release the bus together.
                    r_ce_n      <= 1'b1;
                    r_lb_n      <= 1'b1;
                    r_ub_n      <= 1'b1;
                    r_drive     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                    r_ready     <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_drive <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_async_ctrl
// Self-checking bench for sram_async_ctrl with a behavioural 256Kx16 async
// SRAM on the pins and a word-level reference memory for expected data.
// -----------------------------------------------------------------------------
module tb_sram_async_ctrl;

    localparam int RD_WAIT  = 2;
    localparam int WE_PULSE = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [17:0] req_addr = 18'd0;
    logic [1:0]  req_be = 2'b00;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_async_ctrl #(.RD_WAIT(RD_WAIT), .WE_PULSE(WE_PULSE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    // ---------------- behavioural SRAM on the pins ----------------
    logic [15:0] sram_mem [0:262143];
    logic [15:0] sram_rd;
    assign sram_rd   = sram_mem[sram_addr];
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_rd : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_data[7:0];
            if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_data[15:8];
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];
    logic [16:0] exp_q [$];          // {is_read, expected rsp_rdata}
    logic [15:0] model_last = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic model_issue(input logic we, input logic [17:0] a,
                               input logic [1:0] be, input logic [15:0] wd);
        logic [15:0] cur;
        logic [15:0] e;
        cur = ref_get(int'(a));
        if (we) begin
            if (be[0]) cur[7:0]  = wd[7:0];
            if (be[1]) cur[15:8] = wd[15:8];
            ref_mem[int'(a)] = cur;
            exp_q.push_back({1'b0, model_last});
        end else begin
            e = 16'h0000;
            if (be[0]) e[7:0]  = cur[7:0];
            if (be[1]) e[15:8] = cur[15:8];
            exp_q.push_back({1'b1, e});
            model_last = e;
        end
    endtask

    // ---------------- continuous monitors ----------------
    logic       prev_rsp = 1'b0;
    int         we_len = 0;
    logic [16:0] e_item;

    always @(negedge clk) begin
        if (rst) begin
            prev_rsp = 1'b0;
            we_len   = 0;
        end else begin
            if (!sram_oe_n) begin
                chk("oe_while_drive", {31'd0, dut.r_drive}, 32'd0);
                chk("we_while_oe", {31'd0, sram_we_n}, 32'd1);
            end
            if (!sram_we_n) begin
                we_len++;
            end else if (we_len != 0) begin
                chk("we_pulse_len", we_len, WE_PULSE);
                we_len = 0;
            end
            if (rsp_valid) begin
                chk("rsp_one_cycle", {31'd0, prev_rsp}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e_item = exp_q.pop_front();
                    chk(e_item[16] ? "rd_data" : "rdata_hold", {16'd0, rsp_rdata}, {16'd0, e_item[15:0]});
                end
            end
            prev_rsp = rsp_valid;
        end
    end

    // One access; called and returning at a falling edge.
    task automatic access(input logic we, input logic [17:0] a,
                          input logic [1:0] be, input logic [15:0] wd);
        int n;
        int k;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
        model_issue(we, a, be, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 100) begin k++; @(negedge clk); end
        chk(we ? "wr_latency" : "rd_latency", k, we ? WE_PULSE + 2 : RD_WAIT);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        logic [17:0] ra;
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;

        // 1. reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_lbub_n", {30'd0, sram_lb_n, sram_ub_n}, 32'd3);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // 2. full write, full read
        access(1'b1, 18'h00010, 2'b11, 16'h1234);
        access(1'b0, 18'h00010, 2'b11, 16'h0000);
        // 3. partial write and partial reads
        access(1'b1, 18'h00010, 2'b10, 16'hAB00);
        access(1'b0, 18'h00010, 2'b11, 16'h0000);
        access(1'b0, 18'h00010, 2'b01, 16'h0000);
        access(1'b0, 18'h00010, 2'b00, 16'h0000);
        access(1'b1, 18'h00011, 2'b00, 16'hFFFF);

        // mid-idle reset clears read data
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;
        model_last = 16'h0000;
        @(negedge clk);
        chk("ready_after_idle_rst", {31'd0, req_ready}, 32'd1);

        // 4. req_valid held high: read, write, read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00010; req_be = 2'b11;
        model_issue(1'b0, 18'h00010, 2'b11, 16'h0000);
        @(posedge clk);
        #1 req_we = 1'b1; req_addr = 18'h00020; req_be = 2'b11; req_wdata = 16'h5A5A;
        model_issue(1'b1, 18'h00020, 2'b11, 16'h5A5A);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        chk("ready_low_after_rd", n, RD_WAIT + 1);
        @(posedge clk);
        #1 req_we = 1'b0;
        model_issue(1'b0, 18'h00020, 2'b11, 16'h0000);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        chk("ready_low_after_wr", n, WE_PULSE + 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (RD_WAIT + 3) @(negedge clk);
        chk("q_drained_t4", exp_q.size(), 0);

        // 5. reset during the write pulse
        req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h20000; req_be = 2'b11; req_wdata = 16'hDEAD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (sram_we_n && n < 20) begin n++; @(negedge clk); end
        chk("we_low_seen", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_after", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        model_last = 16'h0000;
        ref_mem.delete(int'(18'h20000));

        // 6. extreme addresses, no aliasing
        access(1'b1, 18'h3FFFF, 2'b11, 16'hBEEF);
        access(1'b1, 18'h00000, 2'b11, 16'h0001);
        access(1'b0, 18'h3FFFF, 2'b11, 16'h0000);
        access(1'b0, 18'h00000, 2'b11, 16'h0000);

        // randomized traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 18'h3FFFF;
                1:       ra = 18'h00000;
                default: ra = 18'h00100 + 18'($urandom_range(0, 7));
            endcase
            access(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)), 16'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("q_drained_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
